// File: rtl/lut_chk_pkg.sv
// Shared types and widths for the LUT3 vector checker.
// Imported by the checker top and its synchronizer.
package lut_chk_pkg;

  localparam int VEC_W   = 3;
  localparam int NUM_VEC = 8;
  localparam int CNT_W   = 4;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// Both flops clear to 0 on reset.
module sync_2ff
  import lut_chk_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/lut3_vector_checker.sv
// Sweeps all eight LUT3 input vectors and compares the
// synchronized LUT output against the INIT truth table.
module lut3_vector_checker
  import lut_chk_pkg::*;
#(
  parameter logic [7:0] INIT          = 8'h8B,
  parameter int         SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [VEC_W-1:0] lut_i,
  input  logic             lut_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [VEC_W-1:0] first_fail_vec,
  output logic             first_fail_valid
);

  state_t           state_q;
  state_t           state_d;
  logic [VEC_W-1:0] vec_q;
  logic [CNT_W-1:0] settle_q;
  logic             lut_sync;
  logic             accept;
  logic             last_vec;
  logic             settle_end;
  logic             mismatch;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (lut_o),
    .q     (lut_sync)
  );

  assign accept = start &&
    (state_q == IDLE || state_q == DONE);
  assign last_vec   = vec_q == VEC_W'(NUM_VEC - 1);
  assign settle_end = settle_q == '0;
  assign mismatch   = lut_sync != INIT[vec_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = DRIVE;
      DRIVE:   state_d = SETTLE;
      SETTLE:  if (settle_end) state_d = SAMPLE;
      SAMPLE:  state_d = last_vec ? DONE : DRIVE;
      DONE:    if (start) state_d = DRIVE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    unique case (state_q)
      DRIVE, SETTLE, SAMPLE: busy = 1'b1;
      default:               busy = 1'b0;
    endcase
    pass = done && (err_count == '0);
  end

  // lut_i is loaded on the edge entering DRIVE so the
  // synchronizer is full by SAMPLE even with one settle cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q            <= '0;
      settle_q         <= '0;
      lut_i            <= '0;
      done             <= 1'b0;
      err_count        <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else if (accept) begin
      vec_q            <= '0;
      lut_i            <= '0;
      done             <= 1'b0;
      err_count        <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: lut_i <= '0;
        DRIVE:
          settle_q <= CNT_W'(SETTLE_CYCLES - 1);
        SETTLE:
          if (!settle_end)
            settle_q <= settle_q - CNT_W'(1);
        SAMPLE: begin
          if (mismatch) begin
            err_count <= err_count + CNT_W'(1);
            if (!first_fail_valid) begin
              first_fail_vec   <= vec_q;
              first_fail_valid <= 1'b1;
            end
          end
          if (!last_vec) begin
            vec_q <= vec_q + VEC_W'(1);
            lut_i <= vec_q + VEC_W'(1);
          end
        end
        DONE: done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/lut3_vector_checker.md
LUT3_VECTOR_CHECKER -- requirements
Module: lut3_vector_checker

Interface
REQ-001 The block SHALL have parameter INIT, default 8'h8B, giving the expected LUT3 truth table, where expected O for input vector v is INIT[v].
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 4, range 1..15, giving the wait cycles between driving a vector and sampling.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit: a one-cycle pulse that requests a sweep.
REQ-006 The block SHALL have port lut_i, output, 3 bits: the vector driven to the LUT3 under test, registered.
REQ-007 The block SHALL have port lut_o, input, 1 bit: the LUT3 output, asynchronous to clk.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a sweep is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: high after a sweep completes, held until the next accepted start.
REQ-010 The block SHALL have port pass, output, 1 bit: equals done AND (err_count == 0).
REQ-011 The block SHALL have port err_count, output, 4 bits: the number of mismatching vectors in the current or last sweep.
REQ-012 The block SHALL have port first_fail_vec, output, 3 bits, and port first_fail_valid, output, 1 bit: the first mismatching vector and its valid flag.

Function
REQ-013 lut_o SHALL pass through a 2-flop synchronizer before any comparison.
REQ-014 The FSM SHALL have states IDLE, DRIVE, SETTLE, SAMPLE and DONE.
REQ-015 In IDLE or DONE, start=1 SHALL be accepted, with the following effects at the next edge:
  - err_count, first_fail_valid and done are cleared.
  - The vector counter is set to 0.
  - The FSM goes to DRIVE.
REQ-016 start SHALL be ignored while busy=1.
REQ-017 DRIVE SHALL last 1 cycle and load lut_i with the vector counter; SETTLE SHALL follow.
REQ-018 SETTLE SHALL last exactly SETTLE_CYCLES cycles, timed by a down-counter, then go to SAMPLE.
REQ-019 SAMPLE SHALL last 1 cycle and compare the synchronized lut_o against INIT[vector]; on mismatch:
  - err_count increments.
  - If first_fail_valid=0, first_fail_vec is loaded with the vector and first_fail_valid is set.
REQ-020 After SAMPLE, vector 7 SHALL go to DONE; otherwise the vector increments and the FSM goes to DRIVE.
REQ-021 Each vector SHALL take SETTLE_CYCLES+2 cycles; done SHALL rise 8*(SETTLE_CYCLES+2)+1 cycles after the accepting edge (default: 49).
REQ-022 busy SHALL be high in DRIVE, SETTLE and SAMPLE, and low otherwise.
REQ-023 err_count SHALL reach at most 8 and need no saturation logic.
REQ-024 lut_i SHALL hold its last value (7) in DONE and be set to 0 in IDLE.
REQ-025 A start coincident with the DONE transition edge SHALL be ignored; start is accepted only while the FSM is already in IDLE or DONE.

Reset
REQ-026 While rst_n=0, the block SHALL asynchronously hold:
  - FSM in IDLE.
  - lut_i=0, busy=0, done=0, pass=0, err_count=0.
  - first_fail_vec=0, first_fail_valid=0.
  - Synchronizer flops and all counters at 0.
REQ-027 Reset asserted mid-sweep SHALL abort the sweep with no partial results retained.
REQ-028 Deassertion of rst_n SHALL take effect at the first clk edge with rst_n=1; a start on that edge is accepted.

Structure
REQ-029 A shared package lut_chk_pkg SHALL define:
  - the FSM state enum;
  - VEC_W=3;
  - NUM_VEC=8;
  - CNT_W=4.
REQ-030 The synchronizer SHALL be a separate sub-module sync_2ff (1-bit, async active-low reset to 0); no other sub-modules.

Verification
REQ-031 Reset then start with a model LUT equal to INIT=8'h8B -> done at cycle 49, pass=1, err_count=0, first_fail_valid=0.
REQ-032 Model LUT forced to constant 1 -> err_count=4, first_fail_vec=2, pass=0.
REQ-033 Model LUT inverted (~INIT) -> err_count=8, first_fail_vec=0.
REQ-034 rst_n pulsed low during SETTLE of vector 3 -> all outputs at reset values immediately; a new start gives a clean full sweep.
REQ-035 start pulsed while busy at cycle 10 -> ignored, done still at cycle 49; a start while done=1 -> done clears next cycle and the sweep reruns.
REQ-036 SETTLE_CYCLES=1 -> done at cycle 25; lut_i steps 0..7, each value held for 3 cycles.
